issue_queue_param: RTL and testbench

//  Parametrised out-of-order issue queue; successor of the fixed 128x8 in-order queue.

---
 rtl/issue_queue_param_pkg.sv | 49 ++++
 rtl/issue_queue_param_if.sv | 34 +++
 rtl/issue_queue_param_age_select.sv | 36 +++
 rtl/issue_queue_param.sv | 167 ++++++++++++++++
 tb/tb_issue_queue_param.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/issue_queue_param_pkg.sv
// Shared types and constants for the parametrised out-of-order issue queue.
package issue_queue_param_pkg;

  localparam int DATA_W   = 64;
  localparam int TAG_W    = 7;
  localparam int ROB_W    = 8;
  localparam int NUM_FU   = 5;
  localparam int FU_CNT_W = 2;
  localparam int NUM_SRC  = 3;
  localparam int CLS_W    = 3;

  typedef enum logic [CLS_W-1:0] {
    FU_INT    = 3'd0,
    FU_MUL    = 3'd1,
    FU_VEC    = 3'd2,
    FU_MEM    = 3'd3,
    FU_BRANCH = 3'd4
  } fu_class_e;

  // Index 0 of op/rdy/src is operand 1.
  typedef struct packed {
    logic [CLS_W-1:0]               cls;
    logic [NUM_SRC-1:0][DATA_W-1:0] op;
    logic [NUM_SRC-1:0]             rdy;
    logic [NUM_SRC-1:0][TAG_W-1:0]  src;
    logic [TAG_W-1:0]               dest;
    logic [ROB_W-1:0]               rob_idx;
    logic [DATA_W-1:0]              pred_mask;
  } iq_uop_t;

  typedef struct packed {
    logic [CLS_W-1:0]               cls;
    logic [NUM_SRC-1:0][DATA_W-1:0] op;
    logic [DATA_W-1:0]              pred_mask;
    logic [TAG_W-1:0]               dest;
    logic [ROB_W-1:0]               rob_idx;
  } iq_issue_t;

  typedef struct packed {
    logic    valid;
    iq_uop_t uop;
  } iq_entry_t;

  // Any out-of-range class code is charged against the branch unit.
  function automatic fu_class_e fu_class_map(input logic [CLS_W-1:0] cls);
    return (cls >= CLS_W'(NUM_FU)) ? FU_BRANCH : fu_class_e'(cls);
  endfunction

endpackage

// File: rtl/issue_queue_param_if.sv
// Dispatch, wakeup, FU budget and issue bundle of the issue queue.
interface issue_queue_param_if #(
  parameter int DEPTH      = 64,
  parameter int DISPATCH_W = 8,
  parameter int ISSUE_W    = 8,
  parameter int WAKE_W     = 8
);
  import issue_queue_param_pkg::*;

  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic [DISPATCH_W-1:0]              disp_valid_i;
  logic                               disp_ready_o;
  iq_uop_t [DISPATCH_W-1:0]           disp_uop_i;
  logic [WAKE_W-1:0]                  wake_valid_i;
  logic [WAKE_W-1:0][TAG_W-1:0]       wake_tag_i;
  logic [WAKE_W-1:0][DATA_W-1:0]      wake_data_i;
  logic [NUM_FU-1:0][FU_CNT_W-1:0]    fu_free_i;
  logic [ISSUE_W-1:0]                 issue_valid_o;
  iq_issue_t [ISSUE_W-1:0]            issue_uop_o;
  logic [PTR_W-1:0]                   occupancy_o;
  logic                               empty_o;

  modport master (
    output disp_valid_i, disp_uop_i, wake_valid_i, wake_tag_i, wake_data_i, fu_free_i,
    input  disp_ready_o, issue_valid_o, issue_uop_o, occupancy_o, empty_o
  );

  modport slave (
    input  disp_valid_i, disp_uop_i, wake_valid_i, wake_tag_i, wake_data_i, fu_free_i,
    output disp_ready_o, issue_valid_o, issue_uop_o, occupancy_o, empty_o
  );

endinterface

// File: rtl/issue_queue_param_age_select.sv
// Oldest-first picker: slot 0 of the inputs is the head, so scanning upward
// walks the queue in age order. Each pick spends one unit of its class budget.
module issue_queue_param_age_select
  import issue_queue_param_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int ISSUE_W = 8
) (
  input  logic [DEPTH-1:0]               elig_rot,
  input  logic [DEPTH-1:0][CLS_W-1:0]    cls_rot,
  input  logic [NUM_FU-1:0][FU_CNT_W-1:0] fu_free,
  output logic [ISSUE_W-1:0][DEPTH-1:0]  pick_rot
);

  // Age-ordered scan; a class with no budget left is skipped, not blocking.
  always_comb begin
    logic [NUM_FU-1:0][FU_CNT_W-1:0] budget;
    int                              picked;
    fu_class_e                       fc;
    budget   = fu_free;
    picked   = 0;
    pick_rot = '0;
    fc       = FU_INT;
    for (int j = 0; j < DEPTH; j++) begin
      fc = fu_class_map(cls_rot[j]);
      if (elig_rot[j] && (picked < ISSUE_W) && (budget[fc] != '0)) begin
        for (int k = 0; k < ISSUE_W; k++) begin
          if (k == picked) pick_rot[k][j] = 1'b1;
        end
        budget[fc] = budget[fc] - FU_CNT_W'(1);
        picked++;
      end
    end
  end

endmodule

// File: rtl/issue_queue_param.sv
// Out-of-order issue queue: entry array with wakeup CAM, compacting dispatch,
// age-ordered select under per-class FU budgets, registered issue lanes.
module issue_queue_param
  import issue_queue_param_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int DISPATCH_W = 8,
  parameter int ISSUE_W    = 8,
  parameter int WAKE_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  issue_queue_param_if.slave io
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  iq_entry_t               entries_reg  [DEPTH];
  iq_entry_t               entries_next [DEPTH];
  logic [PTR_W-1:0]        head_reg, head_next, tail_reg, tail_next;
  logic [ISSUE_W-1:0]      issue_valid_reg, issue_valid_next;
  iq_issue_t [ISSUE_W-1:0] issue_uop_reg, issue_uop_next;

  logic [PTR_W-1:0]             occupancy;
  logic                         disp_ready;
  logic [DEPTH-1:0]             valid_vec;
  logic [DEPTH-1:0]             elig_rot;
  logic [DEPTH-1:0][CLS_W-1:0]  cls_rot;
  logic [ISSUE_W-1:0][DEPTH-1:0] pick_rot;

  // Lowest-numbered matching wake port wins; returns {hit, data}.
  function automatic logic [DATA_W:0] wake_lookup(
    input logic [TAG_W-1:0]                tag,
    input logic [WAKE_W-1:0]               vld,
    input logic [WAKE_W-1:0][TAG_W-1:0]    tags,
    input logic [WAKE_W-1:0][DATA_W-1:0]   data
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int w = WAKE_W - 1; w >= 0; w--) begin
      if (vld[w] && (tags[w] == tag)) res = {1'b1, data[w]};
    end
    return res;
  endfunction

  assign occupancy        = tail_reg - head_reg;
  assign disp_ready       = ({1'b0, PTR_W'(DEPTH)} - {1'b0, occupancy}) >= (PTR_W+1)'(DISPATCH_W);
  assign io.occupancy_o   = occupancy;
  assign io.disp_ready_o  = disp_ready;
  assign io.empty_o       = ~|valid_vec;
  assign io.issue_valid_o = issue_valid_reg;
  assign io.issue_uop_o   = issue_uop_reg;

  // Present the array to the picker rotated so that position 0 is the head.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [IDX_W-1:0] rot_idx;
    assign rot_idx       = head_reg[IDX_W-1:0] + IDX_W'(gi);
    assign valid_vec[gi] = entries_reg[gi].valid;
    assign elig_rot[gi]  = entries_reg[rot_idx].valid & (&entries_reg[rot_idx].uop.rdy);
    assign cls_rot[gi]   = entries_reg[rot_idx].uop.cls;
  end

  issue_queue_param_age_select #(
    .DEPTH   (DEPTH),
    .ISSUE_W (ISSUE_W)
  ) u_select (
    .elig_rot (elig_rot),
    .cls_rot  (cls_rot),
    .fu_free  (io.fu_free_i),
    .pick_rot (pick_rot)
  );

  // Next state: issue picks, wakeup, head retire, then compacted dispatch.
  always_comb begin
    logic [PTR_W-1:0] wr_ptr;
    logic [IDX_W-1:0] slot;
    logic [DATA_W:0]  hit;
    logic [DEPTH-1:0] freed;
    logic             stop;
    entries_next     = entries_reg;
    head_next        = head_reg;
    issue_valid_next = '0;
    issue_uop_next   = '0;
    wr_ptr           = tail_reg;
    slot             = '0;
    hit              = '0;
    freed            = '0;
    stop             = 1'b0;

    for (int k = 0; k < ISSUE_W; k++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (pick_rot[k][j]) begin
          slot                        = head_reg[IDX_W-1:0] + IDX_W'(j);
          issue_valid_next[k]         = 1'b1;
          issue_uop_next[k].cls       = entries_reg[slot].uop.cls;
          issue_uop_next[k].op        = entries_reg[slot].uop.op;
          issue_uop_next[k].pred_mask = entries_reg[slot].uop.pred_mask;
          issue_uop_next[k].dest      = entries_reg[slot].uop.dest;
          issue_uop_next[k].rob_idx   = entries_reg[slot].uop.rob_idx;
          freed[slot]                 = 1'b1;
        end
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (freed[i]) entries_next[i].valid = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
        if (entries_reg[i].valid && !entries_reg[i].uop.rdy[s]) begin
          hit = wake_lookup(entries_reg[i].uop.src[s], io.wake_valid_i, io.wake_tag_i, io.wake_data_i);
          if (hit[DATA_W]) begin
            entries_next[i].uop.rdy[s] = 1'b1;
            entries_next[i].uop.op[s]  = hit[DATA_W-1:0];
          end
        end
      end
    end

    // Head may skip freed slots but never crosses the pre-edge tail.
    for (int k = 0; k < ISSUE_W; k++) begin
      if (!stop && (head_next != tail_reg) && !entries_next[head_next[IDX_W-1:0]].valid)
        head_next = head_next + PTR_W'(1);
      else
        stop = 1'b1;
    end

    if (disp_ready) begin
      for (int l = 0; l < DISPATCH_W; l++) begin
        if (io.disp_valid_i[l]) begin
          slot                     = wr_ptr[IDX_W-1:0];
          entries_next[slot].valid = 1'b1;
          entries_next[slot].uop   = io.disp_uop_i[l];
          for (int s = 0; s < NUM_SRC; s++) begin
            if (!io.disp_uop_i[l].rdy[s]) begin
              hit = wake_lookup(io.disp_uop_i[l].src[s], io.wake_valid_i, io.wake_tag_i, io.wake_data_i);
              if (hit[DATA_W]) begin
                entries_next[slot].uop.rdy[s] = 1'b1;
                entries_next[slot].uop.op[s]  = hit[DATA_W-1:0];
              end
            end
          end
          wr_ptr = wr_ptr + PTR_W'(1);
        end
      end
    end
    tail_next = wr_ptr;
  end

  // State registers; flush clears everything exactly like reset.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head_reg        <= '0;
      tail_reg        <= '0;
      issue_valid_reg <= '0;
      issue_uop_reg   <= '0;
      for (int i = 0; i < DEPTH; i++) entries_reg[i] <= '0;
    end else begin
      head_reg        <= head_next;
      tail_reg        <= tail_next;
      issue_valid_reg <= issue_valid_next;
      issue_uop_reg   <= issue_uop_next;
      for (int i = 0; i < DEPTH; i++) entries_reg[i] <= entries_next[i];
    end
  end

endmodule

// File: tb/tb_issue_queue_param.sv
// Directed bench for issue_queue_param: dispatch, wakeup, bypass, budgets,
// back-pressure, pointer wrap and flush.
module tb_issue_queue_param;
  import issue_queue_param_pkg::*;

  localparam int DEPTH      = 64;
  localparam int DISPATCH_W = 8;
  localparam int ISSUE_W    = 8;
  localparam int WAKE_W     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   exp_rob [3] = '{32, 34, 37};

  issue_queue_param_if #(
    .DEPTH(DEPTH), .DISPATCH_W(DISPATCH_W), .ISSUE_W(ISSUE_W), .WAKE_W(WAKE_W)
  ) bus ();

  issue_queue_param #(
    .DEPTH(DEPTH), .DISPATCH_W(DISPATCH_W), .ISSUE_W(ISSUE_W), .WAKE_W(WAKE_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .io      (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (|bus.issue_valid_o)
      $display("t=%0t issue lanes=%b rob0=%0d occ=%0d", $time, bus.issue_valid_o,
               bus.issue_uop_o[0].rob_idx, bus.occupancy_o);
  endtask

  task automatic idle_inputs();
    bus.disp_valid_i = '0;
    bus.disp_uop_i   = '0;
    bus.wake_valid_i = '0;
    bus.wake_tag_i   = '0;
    bus.wake_data_i  = '0;
  endtask

  task automatic set_free(input logic [1:0] f_int, input logic [1:0] f_mul, input logic [1:0] f_vec,
                          input logic [1:0] f_mem, input logic [1:0] f_br);
    bus.fu_free_i = {f_br, f_mem, f_vec, f_mul, f_int};
  endtask

  function automatic iq_uop_t mk_uop(input logic [2:0] cls, input logic [7:0] rob, input logic [2:0] rdy,
                                     input logic [6:0] src1, input logic [63:0] op1);
    iq_uop_t u;
    u           = '0;
    u.cls       = cls;
    u.rob_idx   = rob;
    u.rdy       = rdy;
    u.src[0]    = src1;
    u.op[0]     = op1;
    u.dest      = rob[6:0];
    u.pred_mask = '1;
    return u;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    idle_inputs();
    bus.fu_free_i = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_issue_valid", 320'(bus.issue_valid_o), 320'(0));
    chk("rst_occupancy",   320'(bus.occupancy_o),   320'(0));
    chk("rst_empty",       320'(bus.empty_o),       320'(1));
    chk("rst_disp_ready",  320'(bus.disp_ready_o),  320'(1));

    // 8 ready int uops, two int units: pairs in rob order
    set_free(2'd2, 2'd0, 2'd0, 2'd0, 2'd0);
    for (int l = 0; l < 8; l++)
      bus.disp_uop_i[l] = mk_uop(FU_INT, 8'(l), 3'b111, 7'd0, 64'h100 + 64'(l));
    bus.disp_valid_i = 8'hFF;
    step();
    idle_inputs();
    chk("t1_no_same_cycle_issue", 320'(bus.issue_valid_o), 320'(0));
    chk("t1_occ8",   320'(bus.occupancy_o), 320'(8));
    chk("t1_empty0", 320'(bus.empty_o),     320'(0));
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t1_valid",     320'(bus.issue_valid_o),          320'(8'h03));
      chk("t1_lane0_rob", 320'(bus.issue_uop_o[0].rob_idx), 320'(2 * c));
      chk("t1_lane1_rob", 320'(bus.issue_uop_o[1].rob_idx), 320'(2 * c + 1));
      chk("t1_lane0_op1", 320'(bus.issue_uop_o[0].op[0]),   320'(64'h100 + 64'(2 * c)));
      chk("t1_occ",       320'(bus.occupancy_o),            320'(6 - 2 * c));
    end
    chk("t1_empty", 320'(bus.empty_o), 320'(1));
    step();
    chk("t1_quiet", 320'(bus.issue_valid_o), 320'(0));

    // Entry0 waits on tag 5, entry1 ready mul
    set_free(2'd2, 2'd2, 2'd0, 2'd0, 2'd0);
    bus.disp_uop_i[0] = mk_uop(FU_INT, 8'd10, 3'b110, 7'd5, 64'h0);
    bus.disp_uop_i[1] = mk_uop(FU_MUL, 8'd11, 3'b111, 7'd0, 64'h77);
    bus.disp_valid_i  = 8'h03;
    step();
    idle_inputs();
    chk("t2_no_same_cycle", 320'(bus.issue_valid_o), 320'(0));
    step();
    chk("t2_mul_valid",    320'(bus.issue_valid_o),          320'(8'h01));
    chk("t2_mul_rob",      320'(bus.issue_uop_o[0].rob_idx), 320'(11));
    chk("t2_unused_lane",  320'(bus.issue_uop_o[1]),         320'(0));
    chk("t2_hole_occ",     320'(bus.occupancy_o),            320'(2));
    bus.wake_valid_i   = 8'b0100_1001;
    bus.wake_tag_i[0]  = 7'd6;
    bus.wake_data_i[0] = 64'hDEAD;
    bus.wake_tag_i[3]  = 7'd5;
    bus.wake_data_i[3] = 64'hABCD;
    bus.wake_tag_i[6]  = 7'd5;
    bus.wake_data_i[6] = 64'h1111;
    step();
    idle_inputs();
    chk("t2_not_yet", 320'(bus.issue_valid_o), 320'(0));
    step();
    chk("t2_woken_valid", 320'(bus.issue_valid_o),          320'(8'h01));
    chk("t2_woken_rob",   320'(bus.issue_uop_o[0].rob_idx), 320'(10));
    chk("t2_woken_op1",   320'(bus.issue_uop_o[0].op[0]),   320'(64'hABCD));
    chk("t2_occ0",        320'(bus.occupancy_o),            320'(0));

    // Dispatch bypass: wake in the same cycle as dispatch
    bus.disp_uop_i[0]  = mk_uop(FU_INT, 8'd20, 3'b110, 7'd9, 64'h0);
    bus.disp_valid_i   = 8'h01;
    bus.wake_valid_i   = 8'h01;
    bus.wake_tag_i[0]  = 7'd9;
    bus.wake_data_i[0] = 64'h1234_5678;
    step();
    idle_inputs();
    chk("t3_no_same_cycle", 320'(bus.issue_valid_o), 320'(0));
    step();
    chk("t3_valid", 320'(bus.issue_valid_o),          320'(8'h01));
    chk("t3_rob",   320'(bus.issue_uop_o[0].rob_idx), 320'(20));
    chk("t3_op1",   320'(bus.issue_uop_o[0].op[0]),   320'(64'h1234_5678));

    // Sparse lanes compact in lane order; one int unit
    set_free(2'd1, 2'd0, 2'd0, 2'd0, 2'd0);
    for (int l = 0; l < 8; l++)
      bus.disp_uop_i[l] = mk_uop(FU_INT, 8'(30 + l), 3'b111, 7'd0, 64'h0);
    bus.disp_valid_i = 8'b1001_0100;
    step();
    idle_inputs();
    chk("t4_occ3", 320'(bus.occupancy_o), 320'(3));
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t4_valid", 320'(bus.issue_valid_o),          320'(8'h01));
      chk("t4_rob",   320'(bus.issue_uop_o[0].rob_idx), 320'(exp_rob[c]));
    end
    chk("t4_occ0", 320'(bus.occupancy_o), 320'(0));

    // Fill to DEPTH-7 with nothing issuing; classes rotate n%5
    set_free(2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    for (int g = 0; g < 8; g++) begin
      for (int l = 0; l < 8; l++)
        bus.disp_uop_i[l] = mk_uop(3'((g * 8 + l) % 5), 8'(g * 8 + l), 3'b111, 7'd0, 64'h0);
      bus.disp_valid_i = (g == 7) ? 8'h01 : 8'hFF;
      step();
    end
    idle_inputs();
    chk("t5_occ57",   320'(bus.occupancy_o),  320'(57));
    chk("t5_ready0",  320'(bus.disp_ready_o), 320'(0));
    bus.disp_valid_i = 8'hFF;
    step();
    idle_inputs();
    chk("t5_dropped_occ",   320'(bus.occupancy_o),  320'(57));
    chk("t5_dropped_ready", 320'(bus.disp_ready_o), 320'(0));
    set_free(2'd2, 2'd2, 2'd2, 2'd2, 2'd2);
    step();
    chk("t5_issue8_valid", 320'(bus.issue_valid_o), 320'(8'hFF));
    for (int k = 0; k < 8; k++)
      chk("t5_issue8_rob", 320'(bus.issue_uop_o[k].rob_idx), 320'(k));
    chk("t5_ready1", 320'(bus.disp_ready_o), 320'(1));
    chk("t5_occ49",  320'(bus.occupancy_o),  320'(49));

    // Drain across the slot 63 -> 0 wrap, age order kept
    for (int c = 0; c < 6; c++) begin
      step();
      chk("t6_drain_valid", 320'(bus.issue_valid_o), 320'(8'hFF));
      for (int k = 0; k < 8; k++)
        chk("t6_drain_rob", 320'(bus.issue_uop_o[k].rob_idx), 320'(8 + 8 * c + k));
    end
    step();
    chk("t6_last_valid", 320'(bus.issue_valid_o),          320'(8'h01));
    chk("t6_last_rob",   320'(bus.issue_uop_o[0].rob_idx), 320'(56));
    chk("t6_occ0",       320'(bus.occupancy_o),            320'(0));
    chk("t6_empty",      320'(bus.empty_o),                320'(1));

    // Flush with 20 entries while 3 are being selected
    set_free(2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    for (int g = 0; g < 3; g++) begin
      for (int l = 0; l < 8; l++)
        bus.disp_uop_i[l] = mk_uop(FU_INT, 8'(100 + g * 8 + l), 3'b111, 7'd0, 64'h0);
      bus.disp_valid_i = (g == 2) ? 8'h0F : 8'hFF;
      step();
    end
    idle_inputs();
    chk("t7_occ20", 320'(bus.occupancy_o), 320'(20));
    set_free(2'd3, 2'd0, 2'd0, 2'd0, 2'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t7_flush_valid", 320'(bus.issue_valid_o),  320'(0));
    chk("t7_flush_uop",   320'(bus.issue_uop_o[0]), 320'(0));
    chk("t7_flush_occ",   320'(bus.occupancy_o),    320'(0));
    chk("t7_flush_empty", 320'(bus.empty_o),        320'(1));
    chk("t7_flush_ready", 320'(bus.disp_ready_o),   320'(1));
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t7_no_stale", 320'(bus.issue_valid_o), 320'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
